// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: byte-strobed word memory with independent read and write paths.
// Write channels are buffered one deep each; reads complete with one cycle of latency.
module axil_mem_slave #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_L;
  endfunction

  function automatic logic [MEM_AW-1:0] mem_addr(input logic [IDX_W-1:0] idx);
    return idx[MEM_AW-1:0];
  endfunction

  // Byte-offset bits carry no meaning for a word-organised memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[OFF_W-1:0], ARADDR[OFF_W-1:0]};

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write path
  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
  logic              w_full_q,  w_full_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;

  logic aw_hs, w_hs, b_hs, commit;

  assign aw_hs  = AWVALID && !aw_full_q;
  assign w_hs   = WVALID  && !w_full_q;
  assign b_hs   = bvalid_q && BREADY;
  // A pending response blocks the next commit, so buffered beats wait for the B handshake.
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = AWADDR[ADDR_W-1:OFF_W];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive ARESETn, only the commit is suppressed.
  always_ff @(posedge ACLK) begin
    if (ARESETn && commit && in_range(aw_idx_q)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) begin
          mem[mem_addr(aw_idx_q)][b*8 +: 8] <= w_data_q[b*8 +: 8];
        end
      end
    end
  end

  assign AWREADY = !aw_full_q;
  assign WREADY  = !w_full_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  // ----------------------------------------------------------------- read path
  logic [0:0]        r_state_q, r_state_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;
  logic [IDX_W-1:0]  ar_idx;

  assign ar_idx = ARADDR[ADDR_W-1:OFF_W];

  // Memory is sampled at the AR edge, so a same-edge write commit is not visible to this read.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          r_state_d = R_RESP;
          if (in_range(ar_idx)) begin
            rdata_d = mem[mem_addr(ar_idx)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_RESP: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_RESP);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares them on every handshake.
module tb_axil_mem_slave;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic                ACLK = 1'b0;
  logic                ARESETn;
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  always #5 ACLK = ~ACLK;

  axil_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } r_exp_t;

  logic [1:0] b_q [$];
  r_exp_t     r_q [$];
  logic [1:0] b_exp;
  r_exp_t     r_exp;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=handshake required=none", name);
  endtask

  // Monitor: a handshake completes at the next posedge when VALID && READY here.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1) begin
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) unexpected("b_unexpected");
        else begin
          b_exp = b_q.pop_front();
          check("bresp", BRESP, b_exp);
        end
      end
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) unexpected("r_unexpected");
        else begin
          r_exp = r_q.pop_front();
          check("rdata", RDATA, r_exp.data);
          check("rresp", RRESP, r_exp.resp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_r(input logic [DATA_W-1:0] data, input logic [1:0] resp);
    r_exp_t e;
    e.data = data;
    e.resp = resp;
    r_q.push_back(e);
  endtask

  // Same-cycle AW+W with BREADY=1: capture, commit, B handshake.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    b_q.push_back(resp);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic [1:0] resp);
    ARADDR = addr; ARVALID = 1'b1;
    push_r(data, resp);
    tick();
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1);
    tick();
    check("arready_after_r", ARREADY, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    tick();
    tick();
    check("rst_awready", AWREADY, 1);
    check("rst_wready",  WREADY,  1);
    check("rst_arready", ARREADY, 1);
    check("rst_bvalid",  BVALID,  0);
    check("rst_rvalid",  RVALID,  0);
    check("rst_bresp",   BRESP,   0);
    check("rst_rresp",   RRESP,   0);
    check("rst_rdata",   RDATA,   0);

    // Same-cycle AW+W accepted on the first edge out of reset.
    ARESETn = 1'b1;
    AWADDR = 13'h010; AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("s1_awready_held", AWREADY, 0);
    check("s1_bvalid_early", BVALID, 0);
    tick();
    check("s1_bvalid", BVALID, 1);
    tick();
    check("s1_bvalid_clear", BVALID, 0);
    do_read(13'h010, 32'hDEADBEEF, 2'b00);

    // W first, AW three cycles later, partial strobe.
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s2_awready_wait", AWREADY, 1);
      check("s2_wready_wait", WREADY, 0);
      tick();
    end
    AWADDR = 13'h010; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("s2_wready_precommit", WREADY, 0);
    check("s2_bvalid_precommit", BVALID, 0);
    tick();
    check("s2_bvalid", BVALID, 1);
    check("s2_wready_free", WREADY, 1);
    tick();
    do_read(13'h010, 32'hDE22BE44, 2'b00);

    // BREADY held low: one extra AW/W buffered, second commit after the B handshake.
    BREADY = 1'b0;
    AWADDR = 13'h020; AWVALID = 1'b1; WDATA = 32'hAAAA5555; WSTRB = 4'hF; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("s3_bvalid_first", BVALID, 1);
    AWADDR = 13'h024; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s3_awready_full", AWREADY, 0);
      check("s3_wready_full", WREADY, 0);
      check("s3_bvalid_hold", BVALID, 1);
      tick();
    end
    BREADY = 1'b1;
    tick();
    check("s3_bvalid_after_hs", BVALID, 0);
    check("s3_awready_still_full", AWREADY, 0);
    tick();
    check("s3_bvalid_second", BVALID, 1);
    check("s3_awready_after_commit", AWREADY, 1);
    tick();
    check("s3_bvalid_clear", BVALID, 0);
    do_read(13'h024, 32'h12345678, 2'b00);
    do_read(13'h020, 32'hAAAA5555, 2'b00);

    // Out-of-range write/read, byte-offset ignored, all-zero strobe.
    do_write(13'h000, 32'h01020304, 4'hF, 2'b00);
    do_write(13'h1000, 32'hFFFFFFFF, 4'hF, 2'b10);
    do_read(13'h000, 32'h01020304, 2'b00);
    do_read(13'h1000, 32'h0, 2'b10);
    do_read(13'h013, 32'hDE22BE44, 2'b00);
    do_write(13'h010, 32'h00000000, 4'h0, 2'b00);
    do_read(13'h010, 32'hDE22BE44, 2'b00);

    // RREADY held low: response stable, no new AR accepted.
    RREADY = 1'b0;
    ARADDR = 13'h020; ARVALID = 1'b1;
    push_r(32'hAAAA5555, 2'b00);
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s5_rvalid_hold", RVALID, 1);
      check("s5_arready_busy", ARREADY, 0);
      check("s5_rdata_stable", RDATA, 32'hAAAA5555);
      tick();
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("s5_arready_back", ARREADY, 1);
    check("s5_rvalid_clear", RVALID, 0);
    RREADY = 1'b1;

    // Read captured on the same edge as a write commit sees the old data.
    do_write(13'h030, 32'h5A5A5A5A, 4'hF, 2'b00);
    AWADDR = 13'h030; AWVALID = 1'b1; WDATA = 32'hC3C3C3C3; WSTRB = 4'hF; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 13'h030; ARVALID = 1'b1;
    push_r(32'h5A5A5A5A, 2'b00);
    tick();
    ARVALID = 1'b0;
    check("s6_bvalid", BVALID, 1);
    check("s6_rvalid", RVALID, 1);
    tick();
    do_read(13'h030, 32'hC3C3C3C3, 2'b00);

    // Reset with a pending B and a buffered AW.
    do_write(13'h044, 32'h44444444, 4'hF, 2'b00);
    BREADY = 1'b0;
    AWADDR = 13'h040; AWVALID = 1'b1; WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("s7_bvalid_pending", BVALID, 1);
    AWADDR = 13'h044; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("s7_aw_buffered", AWREADY, 0);
    ARESETn = 1'b0;
    b_q.delete();
    tick();
    check("s7_rst_bvalid", BVALID, 0);
    check("s7_rst_rvalid", RVALID, 0);
    check("s7_rst_awready", AWREADY, 1);
    check("s7_rst_wready", WREADY, 1);
    check("s7_rst_arready", ARREADY, 1);
    ARESETn = 1'b1;
    BREADY = 1'b1;
    WDATA = 32'h99999999; WSTRB = 4'hF; WVALID = 1'b1;
    b_q.push_back(2'b00);
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s7_no_stale_commit", BVALID, 0);
      tick();
    end
    AWADDR = 13'h048; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    check("s7_bvalid_new", BVALID, 1);
    tick();
    do_read(13'h044, 32'h44444444, 2'b00);
    do_read(13'h040, 32'h77777777, 2'b00);
    do_read(13'h048, 32'h99999999, 2'b00);
    do_read(13'h010, 32'hDE22BE44, 2'b00);

    tick();
    tick();
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
